// File: rtl/bip_control_if.sv
// Instruction-fetch and control-strobe bundle between the BIP control unit and its
// program memory / datapath. The control unit takes the slave side.
interface bip_control_if #(
    parameter int len_data = 16,
    parameter int len_addr = 11
) ();
    logic                i_start;
    logic [len_data-1:0] i_instruction;
    logic [len_addr-1:0] o_pc;
    logic [len_addr-1:0] o_operand;
    logic [1:0]          o_sel_a;
    logic                o_sel_b;
    logic                o_op;
    logic                o_wr_acc;
    logic                o_wr_ram;
    logic                o_rd_ram;
    logic                o_halted;
    logic [len_data-1:0] o_cycle_count;

    modport master (
        output i_start, i_instruction,
        input  o_pc, o_operand, o_sel_a, o_sel_b, o_op,
        input  o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycle_count
    );

    modport slave (
        input  i_start, i_instruction,
        output o_pc, o_operand, o_sel_a, o_sel_b, o_op,
        output o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycle_count
    );
endinterface

// File: rtl/bip_control.sv
// BIP control unit: program counter, opcode decode into datapath strobes,
// IDLE/RUN/HALT sequencing and a saturating count of cycles spent in RUN.
module bip_control #(
    parameter int len_data   = 16,
    parameter int len_addr   = 11,
    parameter int len_opcode = 5
) (
    input  logic             clk,
    input  logic             reset,
    bip_control_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [len_opcode-1:0] OP_HLT  = 5'b00000;
    localparam logic [len_opcode-1:0] OP_STO  = 5'b00001;
    localparam logic [len_opcode-1:0] OP_LD   = 5'b00010;
    localparam logic [len_opcode-1:0] OP_LDI  = 5'b00011;
    localparam logic [len_opcode-1:0] OP_ADD  = 5'b00100;
    localparam logic [len_opcode-1:0] OP_ADDI = 5'b00101;
    localparam logic [len_opcode-1:0] OP_SUB  = 5'b00110;
    localparam logic [len_opcode-1:0] OP_SUBI = 5'b00111;

    state_t              state_q, state_d;
    logic [len_addr-1:0] pc_q, pc_d;
    logic [len_data-1:0] count_q, count_d;

    logic [len_opcode-1:0] opcode;
    logic [1:0]            sel_a;
    logic                  sel_b, op, wr_acc, wr_ram, rd_ram;

    assign opcode = bus.i_instruction[len_data-1 -: len_opcode];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        sel_a   = 2'b00;
        sel_b   = 1'b0;
        op      = 1'b0;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) state_d = RUN;
            end
            RUN: begin
                // Every RUN cycle counts, HLT included; the counter sticks at all-ones.
                if (count_q != '1) count_d = count_q + 1'b1;
                if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 1'b1;
                    case (opcode)
                        OP_STO:  wr_ram = 1'b1;
                        OP_LD:   begin rd_ram = 1'b1; wr_acc = 1'b1; end
                        OP_LDI:  begin sel_a = 2'b01; wr_acc = 1'b1; end
                        OP_ADD:  begin rd_ram = 1'b1; sel_a = 2'b10; wr_acc = 1'b1; end
                        OP_ADDI: begin sel_b = 1'b1; sel_a = 2'b10; wr_acc = 1'b1; end
                        OP_SUB:  begin rd_ram = 1'b1; sel_a = 2'b10; op = 1'b1; wr_acc = 1'b1; end
                        OP_SUBI: begin sel_b = 1'b1; sel_a = 2'b10; op = 1'b1; wr_acc = 1'b1; end
                        default: ;
                    endcase
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_pc          = pc_q;
    assign bus.o_operand     = bus.i_instruction[len_addr-1:0];
    assign bus.o_sel_a       = sel_a;
    assign bus.o_sel_b       = sel_b;
    assign bus.o_op          = op;
    assign bus.o_wr_acc      = wr_acc;
    assign bus.o_wr_ram      = wr_ram;
    assign bus.o_rd_ram      = rd_ram;
    assign bus.o_halted      = (state_q == HALT);
    assign bus.o_cycle_count = count_q;
endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: directed programs against a program-memory array, with an
// abstract model of PC/count/strobes compared every falling edge plus literal checks.
module tb_bip_control;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bip_control_if bus ();

    bip_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [15:0] mem [0:2047];
    logic        ovr     = 1'b0;
    logic [15:0] ovrWord = 16'h0000;
    assign bus.i_instruction = ovr ? ovrWord : mem[bus.o_pc];

    int total = 0;
    int bad   = 0;
    logic chk = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 60) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: machine state, PC and executed-cycle count as plain integers
    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
    mstate_t     mState;
    int          mPc;
    int          mCount;
    logic [15:0] mWord;
    assign mWord = ovr ? ovrWord : mem[mPc[10:0]];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState <= M_IDLE;
            mPc    <= 0;
            mCount <= 0;
        end else begin
            case (mState)
                M_IDLE: if (bus.i_start) mState <= M_RUN;
                M_RUN: begin
                    mCount <= (mCount < 65535) ? mCount + 1 : 65535;
                    if (mWord[15:11] == 5'd0) mState <= M_HALT;
                    else mPc <= (mPc + 1) % 2048;
                end
                default: ;
            endcase
        end
    end

    // Strobe vector {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram} from the instruction table
    function automatic logic [6:0] expStrobes(input logic [4:0] opc);
        int o;
        o = opc;
        if (o >= 4 && o <= 7) begin
            if (o % 2 == 1) return {2'b10, 1'b1, (o >= 6), 1'b1, 1'b0, 1'b0};
            else            return {2'b10, 1'b0, (o >= 6), 1'b1, 1'b0, 1'b1};
        end
        if (o == 1) return 7'b00_0_0_0_1_0;
        if (o == 2) return 7'b00_0_0_1_0_1;
        if (o == 3) return 7'b01_0_0_1_0_0;
        return 7'b0;
    endfunction

    function automatic logic [6:0] dutStrobes();
        return {bus.o_sel_a, bus.o_sel_b, bus.o_op, bus.o_wr_acc, bus.o_wr_ram, bus.o_rd_ram};
    endfunction

    always @(negedge clk) begin
        if (chk) begin
            checkOutput("pc", 32'(bus.o_pc), 32'(mPc));
            checkOutput("operand", 32'(bus.o_operand), 32'(mWord[10:0]));
            checkOutput("strobes", 32'(dutStrobes()),
                        32'((mState == M_RUN) ? expStrobes(mWord[15:11]) : 7'd0));
            checkOutput("halted", 32'(bus.o_halted), 32'(mState == M_HALT));
            checkOutput("count", 32'(bus.o_cycle_count), 32'(mCount));
        end
    end

    task automatic applyStimulus(input logic start);
        bus.i_start = start;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        bus.i_start = 1'b0;
        ovr = 1'b0;
        reset = 1'b0;
        #2;
    endtask

    task automatic releaseReset();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.i_start = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        // 1: reset, then idle with start low
        #1 reset = 1'b0;
        chk = 1'b1;
        #20;
        checkOutput("rst_pc", 32'(bus.o_pc), 32'h0);
        checkOutput("rst_count", 32'(bus.o_cycle_count), 32'h0);
        checkOutput("rst_strobes", 32'(dutStrobes()), 32'h0);
        reset = 1'b1;
        repeat (10) applyStimulus(1'b0);
        checkOutput("idle_pc", 32'(bus.o_pc), 32'h0);
        checkOutput("idle_strobes", 32'(dutStrobes()), 32'h0);
        checkOutput("idle_count", 32'(bus.o_cycle_count), 32'h0);

        // 2: LDI 5, ADDI 3, STO 0x010, HLT
        doReset();
        mem[0] = {5'b00011, 11'h005};
        mem[1] = {5'b00101, 11'h003};
        mem[2] = {5'b00001, 11'h010};
        mem[3] = 16'h0000;
        releaseReset();
        applyStimulus(1'b1);
        checkOutput("ldi_strobes", 32'(dutStrobes()), 32'b01_0_0_1_0_0);
        checkOutput("ldi_operand", 32'(bus.o_operand), 32'h005);
        applyStimulus(1'b0);
        checkOutput("addi_strobes", 32'(dutStrobes()), 32'b10_1_0_1_0_0);
        applyStimulus(1'b0);
        checkOutput("sto_strobes", 32'(dutStrobes()), 32'b00_0_0_0_1_0);
        checkOutput("sto_operand", 32'(bus.o_operand), 32'h010);
        applyStimulus(1'b0);
        checkOutput("hlt_strobes", 32'(dutStrobes()), 32'h0);
        applyStimulus(1'b0);
        checkOutput("halt_pc", 32'(bus.o_pc), 32'h3);
        checkOutput("halt_flag", 32'(bus.o_halted), 32'h1);
        checkOutput("halt_count", 32'(bus.o_cycle_count), 32'h4);

        // 6: HALT ignores start and instruction changes
        ovrWord = {5'b00100, 11'h055};
        ovr = 1'b1;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("frozen_pc", 32'(bus.o_pc), 32'h3);
        checkOutput("frozen_count", 32'(bus.o_cycle_count), 32'h4);
        checkOutput("frozen_strobes", 32'(dutStrobes()), 32'h0);
        checkOutput("frozen_halted", 32'(bus.o_halted), 32'h1);
        ovr = 1'b0;

        // 3: SUB 0x7FF, then an unlisted opcode acting as NOP
        doReset();
        mem[0] = {5'b00110, 11'h7FF};
        mem[1] = {5'b11111, 11'h123};
        mem[2] = {5'b11111, 11'h000};
        mem[3] = 16'h0000;
        releaseReset();
        applyStimulus(1'b1);
        checkOutput("sub_strobes", 32'(dutStrobes()), 32'b10_0_1_1_0_1);
        checkOutput("sub_operand", 32'(bus.o_operand), 32'h7FF);
        applyStimulus(1'b0);
        checkOutput("nop_strobes", 32'(dutStrobes()), 32'h0);
        checkOutput("nop_pc", 32'(bus.o_pc), 32'h1);
        applyStimulus(1'b0);
        checkOutput("nop_pc_inc", 32'(bus.o_pc), 32'h2);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("sub_halt_count", 32'(bus.o_cycle_count), 32'h4);

        // 5: asynchronous reset between edges mid-RUN
        doReset();
        for (int i = 0; i < 2048; i++) mem[i] = {5'b00101, 11'h001};
        releaseReset();
        applyStimulus(1'b1);
        repeat (7) applyStimulus(1'b0);
        checkOutput("pre_rst_pc", 32'(bus.o_pc), 32'h7);
        checkOutput("pre_rst_selb", 32'(bus.o_sel_b), 32'h1);
        #1 reset = 1'b0;
        #1;
        checkOutput("async_pc", 32'(bus.o_pc), 32'h0);
        checkOutput("async_strobes", 32'(dutStrobes()), 32'h0);
        checkOutput("async_count", 32'(bus.o_cycle_count), 32'h0);
        #1 reset = 1'b1;
        repeat (5) applyStimulus(1'b0);
        checkOutput("post_rst_pc", 32'(bus.o_pc), 32'h0);
        checkOutput("post_rst_strobes", 32'(dutStrobes()), 32'h0);

        // 4: PC wrap, then counter saturation over a long NOP run
        doReset();
        for (int i = 0; i < 2048; i++) mem[i] = {5'b01000, 11'(i)};
        releaseReset();
        applyStimulus(1'b1);
        for (int i = 0; i < 3000 && bus.o_pc != 11'h7FE; i++) applyStimulus(1'b0);
        checkOutput("wrap_7fe", 32'(bus.o_pc), 32'h7FE);
        checkOutput("wrap_count", 32'(bus.o_cycle_count), 32'd2046);
        applyStimulus(1'b0);
        checkOutput("wrap_7ff", 32'(bus.o_pc), 32'h7FF);
        applyStimulus(1'b0);
        checkOutput("wrap_000", 32'(bus.o_pc), 32'h000);
        checkOutput("wrap_count2", 32'(bus.o_cycle_count), 32'd2048);
        for (int i = 0; i < 66000 && bus.o_cycle_count != 16'hFFFF; i++) applyStimulus(1'b0);
        checkOutput("sat_reach", 32'(bus.o_cycle_count), 32'hFFFF);
        repeat (3) applyStimulus(1'b0);
        checkOutput("sat_hold", 32'(bus.o_cycle_count), 32'hFFFF);
        checkOutput("sat_pc", 32'(bus.o_pc), 32'h002);

        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
